// File: rtl/sum_uart_pkg.sv
// Shared types and line levels for the sum-word UART transmitter.
// Optional parity build is selected with SUM_UART_TX_PARITY_EN.
package sum_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;
  localparam logic STOP_LVL      = 1'b1;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: 0..CLKS_PER_BIT-1 while enabled, tc on the last count, clr forces 0.
// Single-cycle tc, no backpressure.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_baud_cnt: CLKS_PER_BIT must be in 2..65535");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sum_uart_tx.sv
// Serialises each accepted sum word as UART 8N1 (8E1 with SUM_UART_TX_PARITY_EN), LSB first.
// tx drops on the accept edge; in_ready is high only while IDLE and enabled.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              bit_tc;

  // rst_n gating keeps in_ready low while reset is held even though state already reads IDLE
  assign in_ready = (state_q == IDLE) && ena && rst_n;
  assign tx       = tx_q;
  assign busy     = busy_q;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .en    (state_q != IDLE),
    .tc    (bit_tc)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LVL;
        if (in_valid && in_ready) begin
          state_d = START;
          tx_d    = START_LVL;
          busy_d  = 1'b1;
          shift_d = in_data;
          bit_d   = '0;
`ifdef SUM_UART_TX_PARITY_EN
          par_d   = even_parity(8'(in_data));
`endif
        end
      end
      START: if (bit_tc) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_tc) begin
        if (bit_q == BW'(DATA_W - 1)) begin
`ifdef SUM_UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = STOP_LVL;
`endif
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef SUM_UART_TX_PARITY_EN
      PARITY: if (bit_tc) begin
        state_d = STOP;
        tx_d    = STOP_LVL;
      end
`endif
      STOP: if (bit_tc) begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LVL;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LVL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= UART_IDLE_LVL;
      busy_q  <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Scoreboard bench for sum_uart_tx at CLKS_PER_BIT=4; a line monitor decodes every frame.
// Build with SUM_UART_TX_PARITY_EN to exercise the 8E1 frame.
module tb_sum_uart_tx;

  localparam int CPB = 4;
`ifdef SUM_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  bit mon_en = 1'b0;
  bit mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int starts[$];

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (in_ready && in_valid) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Line monitor: expected frame popped on the start edge, each bit must hold for CPB samples.
  initial begin
    logic [7:0] w;
    logic       bits [NB];
    logic [3:0] smp;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0 && !mon_busy) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        chk("frame_expected", exp_q.size() != 0, 1);
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = w[i];
`ifdef SUM_UART_TX_PARITY_EN
        bits[9] = ^w;
`endif
        bits[NB-1] = 1'b1;
        for (int b = 0; b < NB; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            smp[s] = tx;
          end
          chk($sformatf("w%02h_bit%0d", w, b), smp, {4{bits[b]}});
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready_timeout", t < 200, 1);
    exp_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while ((busy || mon_busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", t < 500, 1);
  endtask

  initial begin
    int n;
    int viol;
    int a0;
    rst_n = 1'b0;
    ena = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    // single frame and busy width
    send(8'h55);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    chk("busy_ready_low", in_ready, 0);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len_55", n, FRAME);
    wait_done();

    // in_valid held: back-to-back frames, one idle cycle between
    starts.delete();
    a0 = acc_cnt;
    send(8'hA3);
    send(8'h0F);
    in_valid = 1'b0;
    wait_done();
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME + 1);
    chk("b2b_accepts", acc_cnt - a0, 2);

    // ena low blocks acceptance
    @(negedge clk);
    ena = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h3C;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || tx !== 1'b1) viol++;
    end
    chk("ena_block", viol, 0);
    ena = 1'b1;
    #1;
    chk("ena_ready", in_ready, 1);
    exp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    chk("ena_start_tx", tx, 0);
    in_valid = 1'b0;
    wait_done();

    // in_data changes while busy are ignored
    send(8'h96);
    in_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      in_data = 8'($urandom);
    end
    wait_done();

    // random words, alternating held valid and gaps
    for (int k = 0; k < 5; k++) begin
      send(8'($urandom));
      if (k[0]) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    wait_done();

`ifdef SUM_UART_TX_PARITY_EN
    send(8'h07);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len_07_par", n, 44);
    wait_done();
    send(8'h03);
    in_valid = 1'b0;
    wait_done();
`endif

    // reset mid-frame at data bit 3
    mon_en = 1'b0;
    send(8'hFF);
    void'(exp_q.pop_back());
    in_valid = 1'b0;
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("post_rst_quiet", viol, 0);
    mon_en = 1'b1;

    send(8'h5A);
    in_valid = 1'b0;
    wait_done();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d exp %0d", cyc, 0);
    $fatal(1);
  end

endmodule
